// File: rtl/pu_riscv_rf_wb_arb.sv
// Shares the integer register file write port between NREQ writeback requesters and the debug unit.
// Also keeps a busy scoreboard. Define RF_WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module pu_riscv_rf_wb_arb #(
  parameter int XLEN    = 64,
  parameter int AR_BITS = 5,
  parameter int NREQ    = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*AR_BITS-1:0] req_dst,
  input  logic [NREQ*XLEN-1:0]    req_dat,
  input  logic                    iss_valid,
  input  logic [AR_BITS-1:0]      iss_dst,
  output logic [31:0]             busy,
  input  logic                    du_stall,
  input  logic                    du_we_rf,
  input  logic [11:0]             du_addr,
  input  logic [XLEN-1:0]         du_dato,
  output logic                    du_ack,
  output logic [AR_BITS-1:0]      rf_dst,
  output logic [XLEN-1:0]         rf_dstv,
  output logic                    rf_we
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DBG_WR, DBG_ACK} state_t;

  state_t              state_reg, state_next;
  logic [AR_BITS-1:0]  dbg_addr_reg, dbg_addr_next;
  logic [XLEN-1:0]     dbg_dat_reg, dbg_dat_next;
  logic                rf_we_reg, rf_we_next;
  logic [AR_BITS-1:0]  rf_dst_reg, rf_dst_next;
  logic [XLEN-1:0]     rf_dstv_reg, rf_dstv_next;
  logic                du_ack_reg, du_ack_next;
  logic [31:0]         busy_reg, busy_next;

  logic                dbg_start;
  logic                arb_en;
  logic                grant_any;
  logic [PW-1:0]       grant_idx;
  logic [AR_BITS-1:0]  grant_dst;
  logic [XLEN-1:0]     grant_dat;

  logic [AR_BITS-1:0]  dst_arr [NREQ];
  logic [XLEN-1:0]     dat_arr [NREQ];

  logic unused_du_addr;
  assign unused_du_addr = &{1'b0, du_addr[11:AR_BITS]};

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign dst_arr[gi] = req_dst[gi*AR_BITS +: AR_BITS];
      assign dat_arr[gi] = req_dat[gi*XLEN +: XLEN];
    end
  endgenerate

  // Debug claims the port in the very cycle it is seen, so requesters lose that cycle too.
  assign dbg_start = du_we_rf & du_stall;
  assign arb_en    = rstn && (state_reg == IDLE) && !dbg_start;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PW'(i);
      end
    end
    if (!arb_en) grant_any = 1'b0;
  end
`else
  logic [PW-1:0] ptr_reg, ptr_next;

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[PW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (!arb_en) grant_any = 1'b0;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end
`endif

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == PW'(i));
    end
  end

  assign grant_dst = dst_arr[grant_idx];
  assign grant_dat = dat_arr[grant_idx];

  always_comb begin
    state_next    = state_reg;
    dbg_addr_next = dbg_addr_reg;
    dbg_dat_next  = dbg_dat_reg;
    rf_we_next    = 1'b0;
    rf_dst_next   = rf_dst_reg;
    rf_dstv_next  = rf_dstv_reg;
    du_ack_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbg_start) begin
          state_next    = DBG_WR;
          dbg_addr_next = du_addr[AR_BITS-1:0];
          dbg_dat_next  = du_dato;
        end else if (grant_any) begin
          rf_we_next   = (grant_dst != '0);
          rf_dst_next  = grant_dst;
          rf_dstv_next = grant_dat;
        end
      end
      DBG_WR: begin
        rf_we_next   = (dbg_addr_reg != '0);
        rf_dst_next  = dbg_addr_reg;
        rf_dstv_next = dbg_dat_reg;
        du_ack_next  = 1'b1;
        state_next   = DBG_ACK;
      end
      DBG_ACK: begin
        // Holding here until the request drops prevents a second write from a level-held request.
        if (!du_we_rf) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0 || gi >= (1 << AR_BITS)) begin : g_const
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_bit, clr_bit;
        assign set_bit = iss_valid && (iss_dst == AR_BITS'(gi));
        assign clr_bit = grant_any && (grant_dst == AR_BITS'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      dbg_addr_reg <= '0;
      dbg_dat_reg  <= '0;
      rf_we_reg    <= 1'b0;
      rf_dst_reg   <= '0;
      rf_dstv_reg  <= '0;
      du_ack_reg   <= 1'b0;
      busy_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      dbg_addr_reg <= dbg_addr_next;
      dbg_dat_reg  <= dbg_dat_next;
      rf_we_reg    <= rf_we_next;
      rf_dst_reg   <= rf_dst_next;
      rf_dstv_reg  <= rf_dstv_next;
      du_ack_reg   <= du_ack_next;
      busy_reg     <= busy_next;
    end
  end

  assign rf_we   = rf_we_reg;
  assign rf_dst  = rf_dst_reg;
  assign rf_dstv = rf_dstv_reg;
  assign du_ack  = du_ack_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_pu_riscv_rf_wb_arb.sv
// Directed bench for pu_riscv_rf_wb_arb: vector table for single-cycle behaviour,
// hand sequences for reset, the debug write handshake and reset during a write.
module tb_pu_riscv_rf_wb_arb;

  localparam int XLEN = 64;
  localparam int AB   = 5;
  localparam int NR   = 3;

  localparam logic [XLEN-1:0] DAT_A = 64'h1111_2222_3333_000A;
  localparam logic [XLEN-1:0] DAT_B = 64'h4444_5555_6666_000B;
  localparam logic [XLEN-1:0] DAT_C = 64'h7777_8888_9999_000C;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AB-1:0]  req_dst;
  logic [NR*XLEN-1:0] req_dat;
  logic              iss_valid;
  logic [AB-1:0]     iss_dst;
  logic [31:0]       busy;
  logic              du_stall;
  logic              du_we_rf;
  logic [11:0]       du_addr;
  logic [XLEN-1:0]   du_dato;
  logic              du_ack;
  logic [AB-1:0]     rf_dst;
  logic [XLEN-1:0]   rf_dstv;
  logic              rf_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pu_riscv_rf_wb_arb #(.XLEN(XLEN), .AR_BITS(AB), .NREQ(NR)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_dat(req_dat),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .busy(busy),
    .du_stall(du_stall), .du_we_rf(du_we_rf), .du_addr(du_addr),
    .du_dato(du_dato), .du_ack(du_ack),
    .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  d0, d1, d2;
    logic        iss_v;
    logic [4:0]  iss_d;
    logic        we_rf;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_dst;
    logic [63:0] e_dat;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic [2:0] valid, logic [4:0] d0, logic [4:0] d1, logic [4:0] d2,
                              logic iss_v, logic [4:0] iss_d, logic we_rf, logic [2:0] e_ready,
                              logic e_we, logic [4:0] e_dst, logic [63:0] e_dat, logic [31:0] e_busy);
    vec_t v;
    v.valid = valid; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.iss_v = iss_v; v.iss_d = iss_d; v.we_rf = we_rf;
    v.e_ready = e_ready; v.e_we = e_we; v.e_dst = e_dst; v.e_dat = e_dat; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_dst = '0; req_dat = {DAT_C, DAT_B, DAT_A};
    iss_valid = 1'b0; iss_dst = '0;
    du_stall = 1'b0; du_we_rf = 1'b0; du_addr = '0; du_dato = '0;
  endtask

  task automatic apply(input int k);
    req_valid = vecs[k].valid;
    req_dst   = {vecs[k].d2, vecs[k].d1, vecs[k].d0};
    iss_valid = vecs[k].iss_v;
    iss_dst   = vecs[k].iss_d;
    du_we_rf  = vecs[k].we_rf;
    du_stall  = 1'b0;
    #1;
    chk($sformatf("vec%0d ready", k), 64'(req_ready), 64'(vecs[k].e_ready));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("vec%0d rf_we", k), 64'(rf_we), 64'(vecs[k].e_we));
    if (vecs[k].e_we) begin
      chk($sformatf("vec%0d rf_dst", k), 64'(rf_dst), 64'(vecs[k].e_dst));
      chk($sformatf("vec%0d rf_dstv", k), rf_dstv, vecs[k].e_dat);
    end
    chk($sformatf("vec%0d busy", k), 64'(busy), 64'(vecs[k].e_busy));
    chk($sformatf("vec%0d du_ack", k), 64'(du_ack), 64'd0);
    $display("vec%0d valid=%b ready=%b rf_we=%b rf_dst=%0d busy=%h", k, vecs[k].valid,
             req_ready, rf_we, rf_dst, busy);
  endtask

  initial begin
    int blocked, writes, acks;
    logic resumed;

    // ready  we  dst  data    busy
    vecs[0]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, DAT_A, 32'h0);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    vecs[1]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, DAT_A, 32'h0);
    vecs[2]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, DAT_A, 32'h0);
`else
    vecs[1]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b010, 1, 6, DAT_B, 32'h0);
    vecs[2]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b100, 1, 7, DAT_C, 32'h0);
`endif
    vecs[3]  = mk(3'b001, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 64'h0, 32'h0);
    vecs[4]  = mk(3'b000, 0, 0, 0, 1, 9, 0, 3'b000, 0, 0, 64'h0, 32'h200);
    vecs[5]  = mk(3'b010, 0, 9, 0, 0, 0, 0, 3'b010, 1, 9, DAT_B, 32'h0);
    vecs[6]  = mk(3'b000, 0, 0, 0, 1, 9, 0, 3'b000, 0, 0, 64'h0, 32'h200);
    vecs[7]  = mk(3'b010, 0, 9, 0, 1, 9, 0, 3'b010, 1, 9, DAT_B, 32'h200);
    vecs[8]  = mk(3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 64'h0, 32'h200);
    vecs[9]  = mk(3'b100, 0, 0, 12, 0, 0, 1, 3'b100, 1, 12, DAT_C, 32'h200);
    vecs[10] = mk(3'b011, 5, 6, 0, 0, 0, 0, 3'b001, 1, 5, DAT_A, 32'h200);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    vecs[11] = mk(3'b011, 5, 6, 0, 0, 0, 0, 3'b001, 1, 5, DAT_A, 32'h200);
`else
    vecs[11] = mk(3'b011, 5, 6, 0, 0, 0, 0, 3'b010, 1, 6, DAT_B, 32'h200);
`endif

    // reset with all requesters asking: nothing may be granted
    idle_inputs();
    rstn = 1'b0;
    req_valid = 3'b111;
    req_dst = {5'd7, 5'd6, 5'd5};
    repeat (2) @(negedge clk);
    chk("reset rf_we", 64'(rf_we), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset du_ack", 64'(du_ack), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rf_dst", 64'(rf_dst), 64'd0);
    chk("reset rf_dstv", rf_dstv, 64'd0);
    $display("reset checked");
    rstn = 1'b1;

    for (int k = 0; k < 12; k++) apply(k);

    // debug write beats a waiting requester
    idle_inputs();
    req_valid = 3'b001; req_dst = {5'd0, 5'd0, 5'd4};
    du_stall = 1'b1; du_we_rf = 1'b1; du_addr = 12'd3; du_dato = 64'hDEAD;
    blocked = 0; writes = 0; acks = 0; resumed = 1'b0;
    for (int c = 0; c < 12 && !resumed; c++) begin
      #1;
      if (du_ack) acks++;
      if (rf_we && rf_dst == 5'd3 && rf_dstv == 64'hDEAD) writes++;
      if (du_ack) begin
        du_we_rf = 1'b0;
        du_stall = 1'b0;
      end
      if (req_ready[0]) begin
        resumed = 1'b1;
      end else begin
        blocked++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("dbg resumed", 64'(resumed), 64'd1);
    chk("dbg blocked cycles", 64'(blocked), 64'd3);
    @(posedge clk);
    @(negedge clk);
    chk("dbg resume rf_we", 64'(rf_we), 64'd1);
    chk("dbg resume rf_dst", 64'(rf_dst), 64'd4);
    chk("dbg resume rf_dstv", rf_dstv, DAT_A);
    if (du_ack) acks++;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    if (du_ack) acks++;
    chk("dbg write count", 64'(writes), 64'd1);
    chk("dbg ack pulses", 64'(acks), 64'd1);
    chk("dbg busy untouched", 64'(busy), 64'h200);
    $display("debug write: blocked=%0d writes=%0d acks=%0d", blocked, writes, acks);

    // reset while a write is on the port
    idle_inputs();
    req_valid = 3'b010; req_dst = {5'd0, 5'd8, 5'd0};
    iss_valid = 1'b1; iss_dst = 5'd11;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("pre-reset rf_we", 64'(rf_we), 64'd1);
    chk("pre-reset busy", 64'(busy), 64'h800 | 64'h200);
    rstn = 1'b0;
    #1;
    chk("async reset rf_we", 64'(rf_we), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    $display("reset mid-write: rf_we=%b busy=%h", rf_we, busy);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
